// File: rtl/led_debug_pager_if.sv
// Bundle of CPU-side debug inputs and LED-side outputs for led_debug_pager.
// master = stimulus/CPU side, slave = the pager itself.
interface led_debug_pager_if #(
  parameter int DATA_W = 32,
  parameter int LED_W  = 8,
  parameter int NUM_CH = 2
);
  localparam int NPG  = NUM_CH * (DATA_W / LED_W) + 1;
  localparam int PG_W = $clog2(NPG);

  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic                     zf;
  logic                     of;
  logic                     flag_valid;
  logic                     clr_flags;
  logic [PG_W-1:0]          sel;
  logic                     auto_en;
  logic                     freeze;
  logic [LED_W-1:0]         led;
  logic [PG_W-1:0]          page;
  logic                     frozen;

  modport master (
    output ch_data, zf, of, flag_valid, clr_flags, sel, auto_en, freeze,
    input  led, page, frozen
  );

  modport slave (
    input  ch_data, zf, of, flag_valid, clr_flags, sel, auto_en, freeze,
    output led, page, frozen
  );
endinterface

// File: rtl/led_debug_pager.sv
// Pages NUM_CH data words plus a ZF/OF flag page onto LED_W board LEDs, manual or auto-scan,
// with a freeze snapshot. led/page are registered: one cycle from sel/data, no backpressure.
module led_debug_pager #(
  parameter int DATA_W   = 32,
  parameter int LED_W    = 8,
  parameter int NUM_CH   = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  led_debug_pager_if.slave  dbg
);
  localparam int PPC   = DATA_W / LED_W;
  localparam int NPG   = NUM_CH * PPC + 1;
  localparam int PG_W  = $clog2(NPG);
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PG_W-1:0] FLAG_PG = PG_W'(NPG - 1);

  typedef enum logic {MANUAL, AUTO} state_t;

  state_t                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [PG_W-1:0]          page_q, page_d, sel_pg;
  logic [LED_W-1:0]         led_q, led_d;
  logic                     frozen_q;
  logic                     sticky_zf_q, sticky_of_q;
  logic                     sticky_zf_d, sticky_of_d;
  logic [NUM_CH*DATA_W-1:0] snap_data_q;
  logic                     snap_zf_q, snap_of_q, snap_szf_q, snap_sof_q;

  logic                     use_snap;
  logic [NUM_CH*DATA_W-1:0] src;
  logic                     disp_zf, disp_of, disp_szf, disp_sof;

  // Out-of-range switch settings all land on the flag page.
  always_comb begin
    sel_pg = dbg.sel;
    if ({{(32-PG_W){1'b0}}, dbg.sel} >= 32'(NPG)) sel_pg = FLAG_PG;
  end

  always_comb begin
    page_d = sel_pg;
    if (dbg.auto_en) begin
      if (state_q == MANUAL)                     page_d = '0;
      else if (cnt_q == CNT_W'(SCAN_DIV - 1))    page_d = (page_q == FLAG_PG) ? '0 : page_q + PG_W'(1);
      else                                       page_d = page_q;
    end
  end

  // On the capture edge the snapshot equals the live values, so live is shown there.
  always_comb begin
    use_snap = dbg.freeze & frozen_q;
    src      = use_snap ? snap_data_q : dbg.ch_data;
    disp_zf  = use_snap ? snap_zf_q   : dbg.zf;
    disp_of  = use_snap ? snap_of_q   : dbg.of;
    disp_szf = use_snap ? snap_szf_q  : sticky_zf_q;
    disp_sof = use_snap ? snap_sof_q  : sticky_of_q;
  end

  always_comb begin
    led_d = '0;
    if (page_d == FLAG_PG) begin
      led_d[LED_W-1] = disp_zf;
      led_d[LED_W-2] = disp_szf;
      led_d[1]       = disp_sof;
      led_d[0]       = disp_of;
    end else begin
      for (int p = 0; p < NPG - 1; p++)
        if (page_d == PG_W'(p)) led_d = src[p*LED_W +: LED_W];
    end
  end

  // A set on the same edge as a clear wins so no flag event is lost.
  always_comb begin
    sticky_zf_d = sticky_zf_q;
    sticky_of_d = sticky_of_q;
    if (dbg.clr_flags) begin
      sticky_zf_d = 1'b0;
      sticky_of_d = 1'b0;
    end
    if (dbg.flag_valid && dbg.zf) sticky_zf_d = 1'b1;
    if (dbg.flag_valid && dbg.of) sticky_of_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MANUAL;
      cnt_q       <= '0;
      page_q      <= '0;
      led_q       <= '0;
      frozen_q    <= 1'b0;
      sticky_zf_q <= 1'b0;
      sticky_of_q <= 1'b0;
      snap_data_q <= '0;
      snap_zf_q   <= 1'b0;
      snap_of_q   <= 1'b0;
      snap_szf_q  <= 1'b0;
      snap_sof_q  <= 1'b0;
    end else begin
      page_q      <= page_d;
      led_q       <= led_d;
      frozen_q    <= dbg.freeze;
      sticky_zf_q <= sticky_zf_d;
      sticky_of_q <= sticky_of_d;
      case (state_q)
        MANUAL: begin
          if (dbg.auto_en) begin
            state_q <= AUTO;
            cnt_q   <= '0;
          end
        end
        AUTO: begin
          if (!dbg.auto_en)                       state_q <= MANUAL;
          else if (cnt_q == CNT_W'(SCAN_DIV - 1)) cnt_q   <= '0;
          else                                    cnt_q   <= cnt_q + CNT_W'(1);
        end
        default: state_q <= MANUAL;
      endcase
      if (dbg.freeze && !frozen_q) begin
        snap_data_q <= dbg.ch_data;
        snap_zf_q   <= dbg.zf;
        snap_of_q   <= dbg.of;
        snap_szf_q  <= sticky_zf_q;
        snap_sof_q  <= sticky_of_q;
      end
    end
  end

  assign dbg.led    = led_q;
  assign dbg.page   = page_q;
  assign dbg.frozen = frozen_q;
endmodule

// File: tb/tb_led_debug_pager.sv
// Directed and randomized bench for led_debug_pager against a page-level behavioural model.
module tb_led_debug_pager;
  localparam int DATA_W   = 32;
  localparam int LED_W    = 8;
  localparam int NUM_CH   = 2;
  localparam int SCAN_DIV = 4;
  localparam int PPC      = DATA_W / LED_W;
  localparam int NPG      = NUM_CH * PPC + 1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  led_debug_pager_if #(.DATA_W(DATA_W), .LED_W(LED_W), .NUM_CH(NUM_CH)) bus ();

  led_debug_pager #(.DATA_W(DATA_W), .LED_W(LED_W), .NUM_CH(NUM_CH), .SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .dbg (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit              m_auto, m_prev_fz, m_frozen;
  int              m_page, m_cnt;
  bit              m_szf, m_sof;
  logic [DATA_W-1:0] m_snap [NUM_CH];
  bit              m_snap_zf, m_snap_of, m_snap_szf, m_snap_sof;
  logic [LED_W-1:0] m_led;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_auto = 0; m_prev_fz = 0; m_frozen = 0; m_page = 0; m_cnt = 0;
    m_szf = 0; m_sof = 0; m_led = '0;
    m_snap_zf = 0; m_snap_of = 0; m_snap_szf = 0; m_snap_sof = 0;
    for (int k = 0; k < NUM_CH; k++) m_snap[k] = '0;
  endtask

  task automatic model_step();
    int nxt;
    logic [DATA_W-1:0] w;
    bit fz;
    if (rst) begin
      model_reset();
      return;
    end
    if (!bus.auto_en) begin
      nxt = (int'(bus.sel) >= NPG) ? NPG - 1 : int'(bus.sel);
      m_auto = 0;
    end else if (!m_auto) begin
      m_auto = 1; m_cnt = 0; nxt = 0;
    end else if (m_cnt == SCAN_DIV - 1) begin
      m_cnt = 0; nxt = (m_page + 1) % NPG;
    end else begin
      m_cnt++; nxt = m_page;
    end
    fz = bus.freeze;
    if (fz && !m_prev_fz) begin
      for (int k = 0; k < NUM_CH; k++) m_snap[k] = bus.ch_data[k*DATA_W +: DATA_W];
      m_snap_zf = bus.zf; m_snap_of = bus.of; m_snap_szf = m_szf; m_snap_sof = m_sof;
    end
    if (nxt == NPG - 1) begin
      m_led = '0;
      m_led[LED_W-1] = fz ? m_snap_zf  : bus.zf;
      m_led[LED_W-2] = fz ? m_snap_szf : m_szf;
      m_led[1]       = fz ? m_snap_sof : m_sof;
      m_led[0]       = fz ? m_snap_of  : bus.of;
    end else begin
      w = fz ? m_snap[nxt / PPC] : bus.ch_data[(nxt / PPC) * DATA_W +: DATA_W];
      m_led = LED_W'(w >> ((nxt % PPC) * LED_W));
    end
    if (bus.flag_valid && bus.zf) m_szf = 1; else if (bus.clr_flags) m_szf = 0;
    if (bus.flag_valid && bus.of) m_sof = 1; else if (bus.clr_flags) m_sof = 0;
    m_prev_fz = fz;
    m_frozen  = fz;
    m_page    = nxt;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_led",    32'(bus.led),    32'(m_led));
    chk("model_page",   32'(bus.page),   32'(m_page));
    chk("model_frozen", 32'(bus.frozen), 32'(m_frozen));
  endtask

  initial begin
    rst            = 1'b1;
    bus.ch_data    = {32'hDEAD_BEEF, 32'hA5A5_1234};
    bus.zf         = 0; bus.of = 0; bus.flag_valid = 0; bus.clr_flags = 0;
    bus.sel        = '0; bus.auto_en = 0; bus.freeze = 0;
    model_reset();
    #2;
    chk("rst_led",    32'(bus.led),    32'h0);
    chk("rst_page",   32'(bus.page),   32'h0);
    chk("rst_frozen", 32'(bus.frozen), 32'h0);

    @(negedge clk); rst = 1'b0; bus.sel = 4'd0; cycle(); chk("sel0", 32'(bus.led), 32'h34);
    bus.sel = 4'd1; cycle(); chk("sel1", 32'(bus.led), 32'h12);
    bus.sel = 4'd2; cycle(); chk("sel2", 32'(bus.led), 32'hA5);
    bus.sel = 4'd3; cycle(); chk("sel3", 32'(bus.led), 32'hA5);
    bus.sel = 4'd4; cycle(); chk("sel4", 32'(bus.led), 32'hEF);
    bus.sel = 4'd7; cycle(); chk("sel7", 32'(bus.led), 32'hDE);

    // Flag page and sticky behaviour
    bus.sel = 4'd8; bus.zf = 1; bus.flag_valid = 1; cycle();
    bus.flag_valid = 0; cycle(); chk("flag_c0", 32'(bus.led), 32'hC0);
    bus.zf = 0; cycle(); chk("flag_40", 32'(bus.led), 32'h40);
    bus.zf = 1; bus.flag_valid = 1; bus.clr_flags = 1; cycle();
    bus.zf = 0; bus.flag_valid = 0; bus.clr_flags = 0; cycle(); chk("set_wins", 32'(bus.led), 32'h40);
    bus.clr_flags = 1; cycle();
    bus.clr_flags = 0; cycle(); chk("cleared", 32'(bus.led), 32'h00);
    bus.sel = 4'd15; cycle(); chk("sel_clamp", 32'(bus.page), 32'd8);

    // Auto-scan: each page held SCAN_DIV cycles, wrapping after the flag page
    bus.auto_en = 1;
    for (int i = 0; i <= NPG * SCAN_DIV; i++) begin
      cycle();
      chk("scan_page", 32'(bus.page), 32'((i / SCAN_DIV) % NPG));
    end
    bus.auto_en = 0; bus.sel = 4'd5; cycle(); chk("auto_off", 32'(bus.page), 32'd5);

    // Freeze snapshot
    bus.sel = 4'd0; bus.ch_data[31:0] = 32'h1111_1111; bus.freeze = 1; cycle();
    bus.ch_data[31:0] = 32'h2222_2222; cycle();
    chk("frz_led", 32'(bus.led), 32'h11);
    chk("frz_flag", 32'(bus.frozen), 32'h1);
    bus.freeze = 0; cycle();
    chk("unfrz_led", 32'(bus.led), 32'h22);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.ch_data    = {$urandom, $urandom};
      bus.zf         = 1'($urandom);
      bus.of         = 1'($urandom);
      bus.flag_valid = ($urandom_range(0, 3) == 0);
      bus.clr_flags  = ($urandom_range(0, 7) == 0);
      bus.sel        = 4'($urandom);
      if ($urandom_range(0, 15) == 0) bus.auto_en = ~bus.auto_en;
      if ($urandom_range(0, 9) == 0)  bus.freeze  = ~bus.freeze;
      cycle();
    end

    // Async reset mid-scan while frozen
    bus.auto_en = 1; bus.freeze = 1; bus.sel = 4'd2;
    for (int i = 0; i < 7; i++) cycle();
    @(posedge clk); #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_led",    32'(bus.led),    32'h0);
    chk("arst_page",   32'(bus.page),   32'h0);
    chk("arst_frozen", 32'(bus.frozen), 32'h0);
    @(negedge clk); rst = 1'b0; bus.freeze = 0; bus.auto_en = 0; bus.sel = 4'd1;
    bus.ch_data = {32'hCAFE_F00D, 32'h0BAD_5EED};
    cycle(); chk("post_rst", 32'(bus.led), 32'h5E);
    bus.auto_en = 1;
    for (int i = 0; i < 6; i++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
